// File: rtl/mul_share_arbiter.sv
// Round-robin front end that time-shares one pipelined multiplier among NREQ requesters.
// A shadow tag pipeline follows each operand pair so the product returns to its issuer.
module mul_share_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NREQ    = 4,
  parameter int LATENCY = 16,
  parameter int MAX_OUT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       resp_valid,
  output logic [2*WIDTH-1:0]    resp_y,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_y,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  // Stage 0 is written together with mul_a/mul_b; the final stage is written
  // on the same edge mul_y presents the matching product.
  localparam int TD = LATENCY + 1;

  logic [CW-1:0]    cnt [NREQ];
  logic [IW-1:0]    ptr;
  logic [TD-1:0]    tag_v;
  logic [IW-1:0]    tag_id [TD];

  logic [NREQ-1:0]  done;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    grant_id;
  logic [IW-1:0]    idx;
  int               sum;
  logic             found;
  logic             xfer;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;

  // Requester whose product is captured into resp_y on the coming edge.
  always_comb begin
    done = '0;
    for (int i = 0; i < NREQ; i++) begin
      done[i] = tag_v[TD-1] && (tag_id[TD-1] == IW'(i));
    end
  end

  // A requester at its cap may still issue when its oldest result retires this edge.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && ((cnt[i] < CW'(MAX_OUT)) || done[i]);
    end
  end

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    sum      = 0;
    idx      = '0;
    for (int off = 0; off < NREQ; off++) begin
      sum = int'(ptr) + off;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IW'(sum);
      if (!found && elig[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Handshake: a transfer happens on a rising edge where req_valid[i] && req_ready[i];
  // req_ready is one-hot or zero, and requesters hold valid/operands until transfer.
  assign req_ready = rst ? '0 : grant;
  assign xfer      = !rst && (|grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a      <= '0;
      mul_b      <= '0;
      resp_y     <= '0;
      resp_valid <= '0;
      busy       <= 1'b0;
      ptr        <= '0;
      tag_v      <= '0;
      for (int j = 0; j < TD; j++) tag_id[j] <= '0;
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      if (xfer) begin
        mul_a <= a_sel;
        mul_b <= b_sel;
        ptr   <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end

      tag_v     <= {tag_v[TD-2:0], xfer};
      tag_id[0] <= grant_id;
      for (int j = 1; j < TD; j++) tag_id[j] <= tag_id[j-1];

      resp_valid <= done;
      if (tag_v[TD-1]) resp_y <= mul_y;

      busy <= (|tag_v[TD-2:0]) || xfer || (|done);

      for (int i = 0; i < NREQ; i++) begin
        case ({xfer && grant[i], done[i]})
          2'b10:   if (cnt[i] != CW'(MAX_OUT)) cnt[i] <= cnt[i] + CW'(1);
          2'b01:   if (cnt[i] != '0) cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural pipelined multiplier
// and an expected-response queue keyed by the cycle each product is due.
module tb_mul_share_arbiter;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int LAT = 16;
  localparam int MO  = 2;
  localparam int EW  = N + 2*W;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     resp_valid;
  logic [2*W-1:0]   resp_y;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   mul_y;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  logic [EW-1:0] exp_q[$];
  int            due_q[$];
  logic [N-1:0]  er;

  mul_share_arbiter #(.WIDTH(W), .NREQ(N), .LATENCY(LAT), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_y(resp_y),
    .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
    .busy(busy)
  );

  // clock / multiplier model: mul_y changes LAT edges after mul_a/mul_b change
  always #5 clk = ~clk;

  logic [2*W-1:0] mpipe [LAT];
  always_ff @(posedge clk) begin
    mpipe[0] <= (2*W)'(mul_a) * (2*W)'(mul_b);
    for (int j = 1; j < LAT; j++) mpipe[j] <= mpipe[j-1];
  end
  assign mul_y = mpipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive valids, check grant, check/score responses, advance.
  task automatic step(input logic [N-1:0] valid, input logic [N-1:0] exp_ready, input string tag);
    logic [EW-1:0]  e;
    logic [2*W-1:0] prod;
    req_valid = valid;
    #1;
    check({tag, " ready"}, 64'(req_ready), 64'(exp_ready));
    if (due_q.size() > 0 && due_q[0] == cyc_n) begin
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      check({tag, " resp_valid"}, 64'(resp_valid), 64'(e[EW-1 -: N]));
      check({tag, " resp_y"}, 64'(resp_y), 64'(e[2*W-1:0]));
    end else begin
      check({tag, " no_resp"}, 64'(resp_valid), 64'(0));
    end
    prod = '0;
    for (int i = 0; i < N; i++) begin
      if (exp_ready[i]) prod = (2*W)'(req_a[i*W +: W]) * (2*W)'(req_b[i*W +: W]);
    end
    if (exp_ready != '0) begin
      exp_q.push_back({exp_ready, prod});
      due_q.push_back(cyc_n + LAT + 2);
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req_valid = '1;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_ready", 64'(req_ready), 64'(0));
      @(posedge clk);
      #1;
      cyc_n++;
    end
    rst = 1'b0;
    req_valid = '0;
    exp_q.delete();
    due_q.delete();
    check("rst_mul_a", 64'(mul_a), 64'(0));
    check("rst_mul_b", 64'(mul_b), 64'(0));
    check("rst_resp_y", 64'(resp_y), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
  endtask

  task automatic single_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp_y);
    logic [N-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    step(oh, oh, "single_issue");
    check("single_mul_a", 64'(mul_a), 64'(a));
    check("single_mul_b", 64'(mul_b), 64'(b));
    check("single_busy_hi", 64'(busy), 64'(1));
    repeat (LAT + 1) step('0, '0, "single_wait");
    check("single_resp_valid", 64'(resp_valid), 64'(oh));
    check("single_resp_y", 64'(resp_y), 64'(exp_y));
    check("single_busy_resp", 64'(busy), 64'(1));
    step('0, '0, "single_tail");
    check("single_busy_lo", 64'(busy), 64'(0));
    check("single_resp_hold", 64'(resp_y), 64'(exp_y));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    do_reset(2);

    // full contention: each requester issues MO ops, stalls, resumes as results retire
    for (int c = 0; c <= 50; c++) begin
      for (int i = 0; i < N; i++) begin
        req_a[i*W +: W] = W'(i + 1);
        req_b[i*W +: W] = W'(10 * c);
      end
      er = '0;
      if (c < 26 && (c % (LAT + 1)) < N*MO) er[(c % (LAT + 1)) % N] = 1'b1;
      step((c < 26) ? '1 : '0, er, "contend");
    end
    check("contend_busy", 64'(busy), 64'(0));

    single_op(0, 16'd3, 16'd5, 32'd15);
    single_op(0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    single_op(3, 16'h0000, 16'hFFFF, 32'h00000000);

    // outstanding cap on requester 2
    req_a[2*W +: W] = 16'd7;
    req_b[2*W +: W] = 16'd9;
    for (int c = 0; c <= LAT + 1; c++) begin
      er = (c <= 1 || c == LAT + 1) ? 4'b0100 : 4'b0000;
      step(4'b0100, er, "cap");
    end
    repeat (LAT + 4) step('0, '0, "cap_drain");
    check("cap_busy", 64'(busy), 64'(0));

    // fairness: 1 and 3 alternate, 0 joins after a grant to 3
    do_reset(1);
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i + 2);
      req_b[i*W +: W] = W'(100 + i);
    end
    step(4'b1010, 4'b0010, "fair0");
    step(4'b1010, 4'b1000, "fair1");
    step(4'b1010, 4'b0010, "fair2");
    step(4'b1010, 4'b1000, "fair3");
    step(4'b1011, 4'b0001, "fair4");
    repeat (LAT + 6) step('0, '0, "fair_drain");
    check("fair_busy", 64'(busy), 64'(0));

    // reset mid-flight: in-flight results must never be reported
    step(4'b0111, 4'b0010, "mid0");
    step(4'b0111, 4'b0100, "mid1");
    step(4'b0111, 4'b0001, "mid2");
    repeat (5) step('0, '0, "mid_wait");
    do_reset(1);
    repeat (LAT + 6) step('0, '0, "mid_quiet");
    step(4'b0001, 4'b0001, "post_cnt0");
    step(4'b0001, 4'b0001, "post_cnt1");
    step(4'b0001, 4'b0000, "post_cnt2");
    repeat (LAT + 4) step('0, '0, "post_drain");
    check("post_busy", 64'(busy), 64'(0));
    single_op(1, 16'h1234, 16'h0010, 32'h00012340);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
